// File: rtl/control_sequencer_if.sv
// control_sequencer_if: the control bundle between the hardwired sequencer and
// the single-bus Mini SRC datapath.
// master: the sequencer (reads IR and Mem_Ready, drives every strobe).
// slave:  the datapath (supplies IR and Mem_Ready, consumes every strobe).
interface control_sequencer_if;
  // Datapath status seen by the sequencer
  logic [31:0] IR;
  logic        Mem_Ready;

  // Bus-source selects
  logic        PC_Out;
  logic        MDR_Out;
  logic        ZHI_Out;
  logic        ZLO_Out;
  logic        HI_Out;
  logic        LO_Out;
  logic        C_Out;
  logic [15:0] R_Out;

  // Register load enables
  logic        PC_In;
  logic        MDR_In;
  logic        MAR_In;
  logic        IR_In;
  logic        Y_In;
  logic        Z_In;
  logic        HI_In;
  logic        LO_In;
  logic [15:0] R_In;

  // PC increment, memory strobes, ALU select and status
  logic        IncPC;
  logic        Read;
  logic        Write;
  logic [3:0]  CONTROL;
  logic        Run;
  logic        Illegal_Op;

  modport master (
    input  IR, Mem_Ready,
    output PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, R_Out,
    output PC_In, MDR_In, MAR_In, IR_In, Y_In, Z_In, HI_In, LO_In, R_In,
    output IncPC, Read, Write, CONTROL, Run, Illegal_Op
  );

  modport slave (
    output IR, Mem_Ready,
    input  PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, R_Out,
    input  PC_In, MDR_In, MAR_In, IR_In, Y_In, Z_In, HI_In, LO_In, R_In,
    input  IncPC, Read, Write, CONTROL, Run, Illegal_Op
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the single-bus Mini SRC
// datapath. Steps one instruction at a time through fetch (T0-T2), decode
// (T3) and execute (T3-T7). All strobes are a combinational decode of the
// state register and IR; memory accesses stall in T1/T6/T7 on Mem_Ready.
// Optional feature: define MUL_DIV_EN to execute mul/div through the HI/LO
// sequence; without it those opcodes take the illegal-opcode path.
module control_sequencer (
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  // One-hot GPR select from a 4-bit register field
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  // ALU operation for every opcode that drives CONTROL during execute.
  // R-type opcodes are laid out in the same order as the ALU encodings.
  function automatic logic [3:0] alu_ctl(input logic [4:0] op);
    logic [4:0] rel;
    rel     = op - OP_ADD;
    alu_ctl = ALU_ADD;
    if (op >= OP_ADD && op <= OP_SHL) alu_ctl = rel[3:0];
    else begin
      case (op)
        OP_ANDI: alu_ctl = ALU_AND;
        OP_ORI:  alu_ctl = ALU_OR;
        OP_NEG:  alu_ctl = ALU_NEG;
        OP_NOT:  alu_ctl = ALU_NOT;
`ifdef MUL_DIV_EN
        OP_DIV:  alu_ctl = ALU_DIV;
        OP_MUL:  alu_ctl = ALU_MUL;
`endif
        default: alu_ctl = ALU_ADD;
      endcase
    end
  endfunction

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_unused_ir;

  logic        w_is_rtype;
  logic        w_is_imm;
  logic        w_is_negnot;
  logic        w_is_muldiv;
  logic        w_is_ld;
  logic        w_is_ldi;
  logic        w_is_st;
  logic        w_is_nop;
  logic        w_is_halt;
  logic [3:0]  w_alu;

  logic        w_pc_out, w_mdr_out, w_zhi_out, w_zlo_out, w_c_out;
  logic        w_mdr_in, w_mar_in, w_ir_in, w_y_in, w_z_in, w_hi_in, w_lo_in;
  logic        w_incpc, w_read, w_write, w_run, w_illegal;
  logic [15:0] w_r_out, w_r_in;
  logic [3:0]  w_control;

  // Instruction fields; the immediate field is consumed by the datapath, not here
  assign w_op        = bus.IR[31:27];
  assign w_ra        = bus.IR[26:23];
  assign w_rb        = bus.IR[22:19];
  assign w_rc        = bus.IR[18:15];
  assign w_unused_ir = ^bus.IR[14:0];

  assign w_is_rtype  = (w_op >= OP_ADD) && (w_op <= OP_SHL);
  assign w_is_imm    = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
  assign w_is_negnot = (w_op == OP_NEG) || (w_op == OP_NOT);
`ifdef MUL_DIV_EN
  assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
`else
  assign w_is_muldiv = 1'b0;
`endif
  assign w_is_ld     = (w_op == OP_LD);
  assign w_is_ldi    = (w_op == OP_LDI);
  assign w_is_st     = (w_op == OP_ST);
  assign w_is_nop    = (w_op == OP_NOP);
  assign w_is_halt   = (w_op == OP_HALT);
  assign w_alu       = alu_ctl(w_op);

  // State register; Clear forces RST immediately so all strobes drop at once
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) r_state <= S_RST;
    else       r_state <= w_next;
  end

  // Next-state and strobe decode from the current state and IR
  always_comb begin
    w_next    = r_state;
    w_pc_out  = 1'b0;
    w_mdr_out = 1'b0;
    w_zhi_out = 1'b0;
    w_zlo_out = 1'b0;
    w_c_out   = 1'b0;
    w_mdr_in  = 1'b0;
    w_mar_in  = 1'b0;
    w_ir_in   = 1'b0;
    w_y_in    = 1'b0;
    w_z_in    = 1'b0;
    w_hi_in   = 1'b0;
    w_lo_in   = 1'b0;
    w_incpc   = 1'b0;
    w_read    = 1'b0;
    w_write   = 1'b0;
    w_run     = 1'b0;
    w_illegal = 1'b0;
    w_r_out   = 16'h0000;
    w_r_in    = 16'h0000;
    w_control = ALU_ADD;

    case (r_state)
      S_RST: begin
        w_next = S_T0;
      end

      S_T0: begin
        w_run    = 1'b1;
        w_pc_out = 1'b1;
        w_mar_in = 1'b1;
        w_incpc  = 1'b1;
        w_next   = S_T1;
      end

      S_T1: begin
        w_run    = 1'b1;
        w_read   = 1'b1;
        w_mdr_in = 1'b1;
        if (bus.Mem_Ready) w_next = S_T2;
      end

      S_T2: begin
        w_run     = 1'b1;
        w_mdr_out = 1'b1;
        w_ir_in   = 1'b1;
        w_next    = S_T3;
      end

      S_T3: begin
        w_run = 1'b1;
        if (w_is_rtype || w_is_imm) begin
          w_r_out = onehot(w_rb);
          w_y_in  = 1'b1;
          w_next  = S_T4;
        end else if (w_is_negnot) begin
          w_r_out   = onehot(w_rb);
          w_control = w_alu;
          w_z_in    = 1'b1;
          w_next    = S_T4;
        end else if (w_is_muldiv) begin
          w_r_out = onehot(w_ra);
          w_y_in  = 1'b1;
          w_next  = S_T4;
        end else if (w_is_ld || w_is_ldi || w_is_st) begin
          // R0 as base register means "no base": the bus carries zero
          w_r_out = (w_rb == 4'd0) ? 16'h0000 : onehot(w_rb);
          w_y_in  = 1'b1;
          w_next  = S_T4;
        end else if (w_is_nop) begin
          w_next = S_T0;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_illegal = 1'b1;
          w_next    = S_T0;
        end
      end

      S_T4: begin
        w_run  = 1'b1;
        w_next = S_T0;
        if (w_is_rtype) begin
          w_r_out   = onehot(w_rc);
          w_control = w_alu;
          w_z_in    = 1'b1;
          w_next    = S_T5;
        end else if (w_is_imm) begin
          w_c_out   = 1'b1;
          w_control = w_alu;
          w_z_in    = 1'b1;
          w_next    = S_T5;
        end else if (w_is_negnot) begin
          w_zlo_out = 1'b1;
          w_r_in    = onehot(w_ra);
        end else if (w_is_muldiv) begin
          w_r_out   = onehot(w_rb);
          w_control = w_alu;
          w_z_in    = 1'b1;
          w_next    = S_T5;
        end else if (w_is_ld || w_is_ldi || w_is_st) begin
          w_c_out   = 1'b1;
          w_control = ALU_ADD;
          w_z_in    = 1'b1;
          w_next    = S_T5;
        end
      end

      S_T5: begin
        w_run  = 1'b1;
        w_next = S_T0;
        if (w_is_rtype || w_is_imm || w_is_ldi) begin
          w_zlo_out = 1'b1;
          w_r_in    = onehot(w_ra);
        end else if (w_is_muldiv) begin
          w_zlo_out = 1'b1;
          w_lo_in   = 1'b1;
          w_next    = S_T6;
        end else if (w_is_ld || w_is_st) begin
          w_zlo_out = 1'b1;
          w_mar_in  = 1'b1;
          w_next    = S_T6;
        end
      end

      S_T6: begin
        w_run  = 1'b1;
        w_next = S_T0;
        if (w_is_muldiv) begin
          w_zhi_out = 1'b1;
          w_hi_in   = 1'b1;
        end else if (w_is_ld) begin
          w_read   = 1'b1;
          w_mdr_in = 1'b1;
          w_next   = bus.Mem_Ready ? S_T7 : S_T6;
        end else if (w_is_st) begin
          // Store data goes onto the bus with Read low so MDR loads from the bus
          w_r_out  = onehot(w_ra);
          w_mdr_in = 1'b1;
          w_next   = S_T7;
        end
      end

      S_T7: begin
        w_run  = 1'b1;
        w_next = S_T0;
        if (w_is_ld) begin
          w_mdr_out = 1'b1;
          w_r_in    = onehot(w_ra);
        end else if (w_is_st) begin
          w_write = 1'b1;
          w_next  = bus.Mem_Ready ? S_T0 : S_T7;
        end
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_RST;
      end
    endcase
  end

  assign bus.PC_Out     = w_pc_out;
  assign bus.MDR_Out    = w_mdr_out;
  assign bus.ZLO_Out    = w_zlo_out;
  assign bus.HI_Out     = 1'b0;
  assign bus.LO_Out     = 1'b0;
  assign bus.C_Out      = w_c_out;
  assign bus.R_Out      = w_r_out;
  assign bus.PC_In      = 1'b0;
  assign bus.MDR_In     = w_mdr_in;
  assign bus.MAR_In     = w_mar_in;
  assign bus.IR_In      = w_ir_in;
  assign bus.Y_In       = w_y_in;
  assign bus.Z_In       = w_z_in;
  assign bus.R_In       = w_r_in;
  assign bus.IncPC      = w_incpc;
  assign bus.Read       = w_read;
  assign bus.Write      = w_write;
  assign bus.CONTROL    = w_control;
  assign bus.Run        = w_run;
  assign bus.Illegal_Op = w_illegal;
`ifdef MUL_DIV_EN
  assign bus.ZHI_Out    = w_zhi_out;
  assign bus.HI_In      = w_hi_in;
  assign bus.LO_In      = w_lo_in;
`else
  // HI/LO path is absent: keep the unused decode terms observable but inert
  assign bus.ZHI_Out    = 1'b0 & w_zhi_out;
  assign bus.HI_In      = 1'b0 & w_hi_in;
  assign bus.LO_In      = 1'b0 & w_lo_in;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer. The driver
// pushes the expected strobe vector for each cycle; a negedge monitor pops it
// and compares against the packed DUT outputs.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear;

  control_sequencer_if sbus();

  control_sequencer u_dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (sbus)
  );

  always #5 Clock = ~Clock;

  // Packed strobe vector layout
  localparam logic [55:0] PC_OUT  = 56'd1 << 55;
  localparam logic [55:0] MDR_OUT = 56'd1 << 54;
  localparam logic [55:0] ZHI_OUT = 56'd1 << 53;
  localparam logic [55:0] ZLO_OUT = 56'd1 << 52;
  localparam logic [55:0] HI_OUT  = 56'd1 << 51;
  localparam logic [55:0] LO_OUT  = 56'd1 << 50;
  localparam logic [55:0] C_OUT   = 56'd1 << 49;
  localparam logic [55:0] PC_IN   = 56'd1 << 48;
  localparam logic [55:0] MDR_IN  = 56'd1 << 47;
  localparam logic [55:0] MAR_IN  = 56'd1 << 46;
  localparam logic [55:0] IR_IN   = 56'd1 << 45;
  localparam logic [55:0] Y_IN    = 56'd1 << 44;
  localparam logic [55:0] Z_IN    = 56'd1 << 43;
  localparam logic [55:0] HI_IN   = 56'd1 << 42;
  localparam logic [55:0] LO_IN   = 56'd1 << 41;
  localparam logic [55:0] INCPC   = 56'd1 << 40;
  localparam logic [55:0] READ    = 56'd1 << 39;
  localparam logic [55:0] WRITE   = 56'd1 << 38;
  localparam logic [55:0] RUN     = 56'd1 << 37;
  localparam logic [55:0] ILLEGAL = 56'd1 << 36;

  typedef struct {
    string       tag;
    logic [55:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic logic [55:0] rout(input int idx);
    logic [55:0] v;
    v = 56'd1 << (16 + idx);
    return v;
  endfunction

  function automatic logic [55:0] rin(input int idx);
    logic [55:0] v;
    v = 56'd1 << idx;
    return v;
  endfunction

  function automatic logic [55:0] ctl(input int c);
    logic [55:0] v;
    v = 56'(c & 15) << 32;
    return v;
  endfunction

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    logic [31:0] v;
    v = {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'h0000};
    return v;
  endfunction

  function automatic logic [55:0] sample();
    return {sbus.PC_Out, sbus.MDR_Out, sbus.ZHI_Out, sbus.ZLO_Out, sbus.HI_Out,
            sbus.LO_Out, sbus.C_Out, sbus.PC_In, sbus.MDR_In, sbus.MAR_In,
            sbus.IR_In, sbus.Y_In, sbus.Z_In, sbus.HI_In, sbus.LO_In,
            sbus.IncPC, sbus.Read, sbus.Write, sbus.Run, sbus.Illegal_Op,
            sbus.CONTROL, sbus.R_Out, sbus.R_In};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: compare the strobes of the state entered at the last rising edge
  always @(negedge Clock) begin
    sb_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_val(e.tag, 64'(sample()), 64'(e.exp));
    end
  end

  // One clock: drive inputs, queue this cycle's expected strobes, advance
  task automatic cyc(input logic mr, input logic clr, input string tag, input logic [55:0] ev);
    sb_t e;
    sbus.Mem_Ready = mr;
    Clear          = clr;
    e.tag          = tag;
    e.exp          = ev;
    sbq.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input int waits);
    cyc(1'b1, 1'b0, "T0", RUN | PC_OUT | MAR_IN | INCPC);
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, "T1_wait", RUN | READ | MDR_IN);
    cyc(1'b1, 1'b0, "T1", RUN | READ | MDR_IN);
    cyc(1'b1, 1'b0, "T2", RUN | MDR_OUT | IR_IN);
  endtask

  initial begin
    Clear          = 1'b1;
    sbus.IR        = 32'h0;
    sbus.Mem_Ready = 1'b0;
    @(posedge Clock);
    #1;

    // Reset: all outputs zero while Clear held, and in RST right after release
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, "rst_hold", 56'd0);
    cyc(1'b0, 1'b0, "rst_release", 56'd0);

    // add R1,R2,R3
    sbus.IR = 32'h18918000;
    fetch(0);
    cyc(1'b1, 1'b0, "add_T3", RUN | rout(2) | Y_IN);
    cyc(1'b1, 1'b0, "add_T4", RUN | rout(3) | Z_IN | ctl(0));
    cyc(1'b1, 1'b0, "add_T5", RUN | ZLO_OUT | rin(1));

    // ld R1,0x55(R0) with three wait cycles in T6
    sbus.IR = 32'h00800055;
    fetch(0);
    cyc(1'b0, 1'b0, "ld_T3", RUN | Y_IN);
    cyc(1'b0, 1'b0, "ld_T4", RUN | C_OUT | Z_IN | ctl(0));
    cyc(1'b0, 1'b0, "ld_T5", RUN | ZLO_OUT | MAR_IN);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "ld_T6_wait", RUN | READ | MDR_IN);
    cyc(1'b1, 1'b0, "ld_T6", RUN | READ | MDR_IN);
    cyc(1'b1, 1'b0, "ld_T7", RUN | MDR_OUT | rin(1));

    // st 0x10(R0),R2 with two wait cycles in T7
    sbus.IR = 32'h11000010;
    fetch(0);
    cyc(1'b1, 1'b0, "st_T3", RUN | Y_IN);
    cyc(1'b1, 1'b0, "st_T4", RUN | C_OUT | Z_IN | ctl(0));
    cyc(1'b1, 1'b0, "st_T5", RUN | ZLO_OUT | MAR_IN);
    cyc(1'b1, 1'b0, "st_T6", RUN | rout(2) | MDR_IN);
    cyc(1'b0, 1'b0, "st_T7_wait", RUN | WRITE);
    cyc(1'b0, 1'b0, "st_T7_wait", RUN | WRITE);
    cyc(1'b1, 1'b0, "st_T7", RUN | WRITE);

    // mul R1,R3
    sbus.IR = 32'h80980000;
    fetch(0);
`ifdef MUL_DIV_EN
    cyc(1'b1, 1'b0, "mul_T3", RUN | rout(1) | Y_IN);
    cyc(1'b1, 1'b0, "mul_T4", RUN | rout(3) | Z_IN | ctl(10));
    cyc(1'b1, 1'b0, "mul_T5", RUN | ZLO_OUT | LO_IN);
    cyc(1'b1, 1'b0, "mul_T6", RUN | ZHI_OUT | HI_IN);
`else
    cyc(1'b1, 1'b0, "mul_illegal_T3", RUN | ILLEGAL);
`endif

    // div R4,R5
    sbus.IR = mk(15, 4, 5, 0);
    fetch(0);
`ifdef MUL_DIV_EN
    cyc(1'b1, 1'b0, "div_T3", RUN | rout(4) | Y_IN);
    cyc(1'b1, 1'b0, "div_T4", RUN | rout(5) | Z_IN | ctl(9));
    cyc(1'b1, 1'b0, "div_T5", RUN | ZLO_OUT | LO_IN);
    cyc(1'b1, 1'b0, "div_T6", RUN | ZHI_OUT | HI_IN);
`else
    cyc(1'b1, 1'b0, "div_illegal_T3", RUN | ILLEGAL);
`endif

    // neg R4,R5 and not R9,R15
    sbus.IR = mk(17, 4, 5, 0);
    fetch(0);
    cyc(1'b1, 1'b0, "neg_T3", RUN | rout(5) | Z_IN | ctl(11));
    cyc(1'b1, 1'b0, "neg_T4", RUN | ZLO_OUT | rin(4));
    sbus.IR = mk(18, 9, 15, 0);
    fetch(0);
    cyc(1'b1, 1'b0, "not_T3", RUN | rout(15) | Z_IN | ctl(12));
    cyc(1'b1, 1'b0, "not_T4", RUN | ZLO_OUT | rin(9));

    // All R-type ops, distinct register fields each time
    for (int op = 3; op <= 11; op++) begin
      sbus.IR = mk(op, op, op + 1, op + 2);
      fetch(0);
      cyc(1'b1, 1'b0, "rtype_T3", RUN | rout(op + 1) | Y_IN);
      cyc(1'b1, 1'b0, "rtype_T4", RUN | rout(op + 2) | Z_IN | ctl(op - 3));
      cyc(1'b1, 1'b0, "rtype_T5", RUN | ZLO_OUT | rin(op));
    end

    // Immediate ops, with a two-cycle fetch stall on the first one
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (k == 0) ? 0 : (k == 1) ? 2 : 3;
      sbus.IR = mk(12 + k, 6 + k, 7 + k, 0);
      fetch((k == 0) ? 2 : 0);
      cyc(1'b1, 1'b0, "imm_T3", RUN | rout(7 + k) | Y_IN);
      cyc(1'b1, 1'b0, "imm_T4", RUN | C_OUT | Z_IN | ctl(c));
      cyc(1'b1, 1'b0, "imm_T5", RUN | ZLO_OUT | rin(6 + k));
    end

    // ldi R5,imm(R3): nonzero base drives R_Out
    sbus.IR = mk(1, 5, 3, 0);
    fetch(0);
    cyc(1'b0, 1'b0, "ldi_T3", RUN | rout(3) | Y_IN);
    cyc(1'b0, 1'b0, "ldi_T4", RUN | C_OUT | Z_IN | ctl(0));
    cyc(1'b0, 1'b0, "ldi_T5", RUN | ZLO_OUT | rin(5));

    // Unsupported opcode and nop
    sbus.IR = mk(20, 1, 2, 3);
    fetch(0);
    cyc(1'b1, 1'b0, "illegal_T3", RUN | ILLEGAL);
    sbus.IR = mk(26, 1, 2, 3);
    fetch(0);
    cyc(1'b1, 1'b0, "nop_T3", RUN);

    // Clear asserted in T6 of an ld: strobes drop at once, no R_In follows
    sbus.IR = 32'h00800055;
    fetch(0);
    cyc(1'b0, 1'b0, "ldc_T3", RUN | Y_IN);
    cyc(1'b0, 1'b0, "ldc_T4", RUN | C_OUT | Z_IN | ctl(0));
    cyc(1'b0, 1'b0, "ldc_T5", RUN | ZLO_OUT | MAR_IN);
    cyc(1'b0, 1'b0, "ldc_T6", RUN | READ | MDR_IN);
    cyc(1'b1, 1'b1, "ldc_clear", 56'd0);
    cyc(1'b1, 1'b0, "ldc_rst", 56'd0);

    // halt: ten idle cycles, then Clear back to RST and T0
    sbus.IR = mk(27, 0, 0, 0);
    fetch(0);
    cyc(1'b1, 1'b0, "halt_T3", RUN);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, "halt_idle", 56'd0);
    cyc(1'b1, 1'b1, "halt_clear", 56'd0);
    cyc(1'b1, 1'b0, "halt_rst", 56'd0);
    cyc(1'b1, 1'b0, "halt_T0", RUN | PC_OUT | MAR_IN | INCPC);

    check_val("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
